// File: rtl/cpu6_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu6_wb_ctrl_pkg
// Shared definitions for the CPU6 writeback controller:
//   CPU6_XLEN          - register data width
//   CPU6_RFIDX_WIDTH   - register index width
//   CPU6_RFREG_NUM     - number of architectural registers
//   wb_state_e         - starvation FSM state encoding
//   rf_idx_nz()        - true when an index names a writable register (not x0)
// -----------------------------------------------------------------------------
package cpu6_wb_ctrl_pkg;

    localparam int CPU6_XLEN        = 32;
    localparam int CPU6_RFIDX_WIDTH = 5;
    localparam int CPU6_RFREG_NUM   = 32;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'b00,
        WB_WAIT  = 2'b01,
        WB_FORCE = 2'b10
    } wb_state_e;

    // x0 is hard-wired zero: it is never written and never pending.
    function automatic logic rf_idx_nz(input logic [CPU6_RFIDX_WIDTH-1:0] idx);
        return |idx;
    endfunction

endpackage

// File: rtl/cpu6_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// cpu6_wb_scoreboard
// Tracks registers that are destinations of issued-but-not-written-back loads
// and flags dispatching instructions that touch any of them.
// Built only when CPU6_WB_SCOREBOARD_EN is defined; otherwise hazard_o is 0 and
// the issue/clear inputs are ignored.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   iss_valid_i/idx_i    load issued: mark destination pending
//   clr_valid_i/idx_i    load writeback handshake: clear destination
//   rs1/rs2/rd_idx_i     operands of the dispatching instruction
//   hazard_o             any operand is pending (combinational)
// -----------------------------------------------------------------------------
module cpu6_wb_scoreboard
    import cpu6_wb_ctrl_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        iss_valid_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] iss_idx_i,
    input  logic                        clr_valid_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] clr_idx_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] rs1_idx_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] rs2_idx_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] rd_idx_i,
    output logic                        hazard_o
);

`ifdef CPU6_WB_SCOREBOARD_EN
    logic [CPU6_RFREG_NUM-1:1] pending_q;
    logic [CPU6_RFREG_NUM-1:1] pending_d;
    logic [CPU6_RFREG_NUM-1:0] pend_vec_s;

    // Next pending set: a fresh issue to the same register beats its clear.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < CPU6_RFREG_NUM; i++) begin
            if (iss_valid_i && (iss_idx_i == CPU6_RFIDX_WIDTH'(i))) begin
                pending_d[i] = 1'b1;
            end else if (clr_valid_i && (clr_idx_i == CPU6_RFIDX_WIDTH'(i))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // Pending-bit storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Bit 0 is a constant zero so x0 operands never raise a hazard.
    assign pend_vec_s = {pending_q, 1'b0};
    assign hazard_o   = pend_vec_s[rs1_idx_i] | pend_vec_s[rs2_idx_i] | pend_vec_s[rd_idx_i];
`else
    logic unused_sb_s;
    assign unused_sb_s = ^{clk_i, rst_ni, iss_valid_i, iss_idx_i, clr_valid_i,
                           clr_idx_i, rs1_idx_i, rs2_idx_i, rd_idx_i};
    assign hazard_o    = 1'b0;
`endif

endmodule

// File: rtl/cpu6_wb_ctrl.sv
// -----------------------------------------------------------------------------
// cpu6_wb_ctrl
// Register-file writeback arbiter between the ALU (cannot stall) and the LSU
// (valid/ready), with an anti-starvation FSM that briefly holds the ALU, and an
// optional load scoreboard (macro CPU6_WB_SCOREBOARD_EN).
// Parameter:
//   STARVE_LIMIT   consecutive refused LSU cycles before the ALU is held
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   alu_wb_valid_i/idx_i/data_i         ALU writeback (always wins)
//   alu_hold_o                          ALU must withhold next cycle's writeback
//   lsu_wb_valid_i/idx_i/data_i         LSU writeback offer
//   lsu_wb_ready_o                      LSU writeback accepted this cycle
//   lsu_issue_valid_i/idx_i             load issued (scoreboard set)
//   chk_rs1/rs2/rd_idx_i, hazard_o      dispatch hazard check
//   rd_wen_o/rd_idx_o/rd_data_o         registered register-file write port
// -----------------------------------------------------------------------------
module cpu6_wb_ctrl
    import cpu6_wb_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        alu_wb_valid_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] alu_wb_idx_i,
    input  logic [CPU6_XLEN-1:0]        alu_wb_data_i,
    output logic                        alu_hold_o,
    input  logic                        lsu_wb_valid_i,
    output logic                        lsu_wb_ready_o,
    input  logic [CPU6_RFIDX_WIDTH-1:0] lsu_wb_idx_i,
    input  logic [CPU6_XLEN-1:0]        lsu_wb_data_i,
    input  logic                        lsu_issue_valid_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] lsu_issue_idx_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] chk_rs1_idx_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] chk_rs2_idx_i,
    input  logic [CPU6_RFIDX_WIDTH-1:0] chk_rd_idx_i,
    output logic                        hazard_o,
    output logic                        rd_wen_o,
    output logic [CPU6_RFIDX_WIDTH-1:0] rd_idx_o,
    output logic [CPU6_XLEN-1:0]        rd_data_o
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

    logic                        lsu_ready_s;
    logic                        refused_s;
    logic                        win_s;
    logic [CPU6_RFIDX_WIDTH-1:0] win_idx_s;
    logic [CPU6_XLEN-1:0]        win_data_s;
    logic                        rd_wen_d;

    wb_state_e                   state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        hold_q;
    logic                        rd_wen_q;
    logic [CPU6_RFIDX_WIDTH-1:0] rd_idx_q;
    logic [CPU6_XLEN-1:0]        rd_data_q;

    assign lsu_ready_s = lsu_wb_valid_i & ~alu_wb_valid_i;
    assign refused_s   = lsu_wb_valid_i & alu_wb_valid_i;

    // Fixed-priority winner selection: ALU first, then LSU.
    always_comb begin
        win_s      = 1'b0;
        win_idx_s  = '0;
        win_data_s = '0;
        if (alu_wb_valid_i) begin
            win_s      = 1'b1;
            win_idx_s  = alu_wb_idx_i;
            win_data_s = alu_wb_data_i;
        end else if (lsu_wb_valid_i) begin
            win_s      = 1'b1;
            win_idx_s  = lsu_wb_idx_i;
            win_data_s = lsu_wb_data_i;
        end else begin
            win_s      = 1'b0;
            win_idx_s  = '0;
            win_data_s = '0;
        end
    end

    // A winner targeting x0 still handshakes but never writes.
    assign rd_wen_d = win_s & rf_idx_nz(win_idx_s);

    // Write-port flops; index/data load only when there is a winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_wen_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_wen_q <= rd_wen_d;
            if (win_s) begin
                rd_idx_q  <= win_idx_s;
                rd_data_q <= win_data_s;
            end
        end
    end

    // Starvation FSM. In FORCE, hold_q alternates: the hold cycle (hold_q=1)
    // is followed by a cycle where the ALU should be absent; an ALU that shows
    // up anyway still wins and re-arms the hold. FORCE exits as soon as the
    // ALU is absent, which is exactly when the LSU gets through.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (refused_s) begin
                        cnt_q <= ONE_C;
                        if (ONE_C >= LIMIT_C) begin
                            state_q <= WB_FORCE;
                            hold_q  <= 1'b1;
                        end else begin
                            state_q <= WB_WAIT;
                            hold_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= WB_IDLE;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end
                end
                WB_WAIT: begin
                    if (refused_s) begin
                        if ((cnt_q + ONE_C) >= LIMIT_C) begin
                            state_q <= WB_FORCE;
                            cnt_q   <= LIMIT_C;
                            hold_q  <= 1'b1;
                        end else begin
                            state_q <= WB_WAIT;
                            cnt_q   <= cnt_q + ONE_C;
                            hold_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= WB_IDLE;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end
                end
                WB_FORCE: begin
                    if (alu_wb_valid_i) begin
                        state_q <= WB_FORCE;
                        cnt_q   <= LIMIT_C;
                        hold_q  <= ~hold_q;
                    end else begin
                        state_q <= WB_IDLE;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WB_IDLE;
                    cnt_q   <= '0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    cpu6_wb_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .iss_valid_i (lsu_issue_valid_i),
        .iss_idx_i   (lsu_issue_idx_i),
        .clr_valid_i (lsu_ready_s),
        .clr_idx_i   (lsu_wb_idx_i),
        .rs1_idx_i   (chk_rs1_idx_i),
        .rs2_idx_i   (chk_rs2_idx_i),
        .rd_idx_i    (chk_rd_idx_i),
        .hazard_o    (hazard_o)
    );

    assign lsu_wb_ready_o = lsu_ready_s;
    assign alu_hold_o     = hold_q;
    assign rd_wen_o       = rd_wen_q;
    assign rd_idx_o       = rd_idx_q;
    assign rd_data_o      = rd_data_q;

endmodule

// File: doc/cpu6_wb_ctrl.md
CPU6_WB_CTRL -- requirements
Module: cpu6_wb_ctrl

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning: consecutive cycles an LSU writeback may lose arbitration before the ALU is held.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_wb_valid  input  1  ALU result present this cycle; cannot be back-pressured.
REQ-005 alu_wb_idx  input  CPU6_RFIDX_WIDTH  ALU destination register.
REQ-006 alu_wb_data  input  CPU6_XLEN  ALU result.
REQ-007 alu_hold  output  1  next cycle's ALU writeback must be withheld upstream.
REQ-008 lsu_wb_valid  input  1  load data offered.
REQ-009 lsu_wb_ready  output  1  load data accepted this cycle.
REQ-010 lsu_wb_idx  input  CPU6_RFIDX_WIDTH  load destination register.
REQ-011 lsu_wb_data  input  CPU6_XLEN  load data.
REQ-012 lsu_issue_valid  input  1  load issued; marks its destination pending.
REQ-013 lsu_issue_idx  input  CPU6_RFIDX_WIDTH  issued load destination.
REQ-014 chk_rs1_idx, chk_rs2_idx, chk_rd_idx  input  CPU6_RFIDX_WIDTH each  dispatching instruction's operands.
REQ-015 hazard  output  1  dispatching instruction touches a pending register.
REQ-016 rd_wen  output  1  register-file write enable.
REQ-017 rd_idx  output  CPU6_RFIDX_WIDTH  register-file write index.
REQ-018 rd_data  output  CPU6_XLEN  register-file write data.

Function
REQ-019 Writeback arbitration: alu_wb_valid wins; otherwise lsu_wb_valid wins; lsu_wb_ready = lsu_wb_valid & ~alu_wb_valid (combinational).
REQ-020 rd_wen/rd_idx/rd_data are registered: winner's write appears exactly one cycle after acceptance; rd_wen low when no winner.
REQ-021 A winner with index 0 completes its handshake but drives rd_wen low.
REQ-022 FSM states IDLE, WAIT, FORCE: IDLE->WAIT when LSU valid and refused; WAIT counts refused cycles; WAIT->IDLE on LSU acceptance or valid dropping; WAIT->FORCE when count reaches STARVE_LIMIT.
REQ-023 In FORCE, alu_hold=1 for exactly one cycle; the following cycle ALU is absent, LSU is accepted, FSM returns to IDLE.
REQ-024 If alu_wb_valid is asserted despite alu_hold, the ALU still wins and the FSM stays in FORCE re-asserting alu_hold.
REQ-025 Starvation counter saturates at STARVE_LIMIT and clears on return to IDLE.
REQ-026 Scoreboard pending[31:1]: set on lsu_issue_valid (idx != 0), cleared on LSU handshake of that idx; set wins over clear for the same idx in the same cycle.
REQ-027 hazard = pending[chk_rs1_idx] | pending[chk_rs2_idx] | pending[chk_rd_idx], combinational from current state; index 0 never pending.

Reset
REQ-028 On rst low: rd_wen=0, rd_idx=0, rd_data=0, alu_hold=0, FSM=IDLE, counter=0, all pending bits 0; effective immediately and independent of clk.
REQ-029 Reset mid-FORCE or mid-WAIT discards the in-progress starvation state; outstanding loads are forgotten.

Configuration
REQ-030 Macro CPU6_WB_SCOREBOARD_EN defined: scoreboard and hazard behave per REQ-026/027.
REQ-031 Macro CPU6_WB_SCOREBOARD_EN undefined: no pending storage is built, hazard is tied 0, lsu_issue_* are ignored; arbitration is unchanged.

Structure
REQ-032 CPU6_XLEN, CPU6_RFIDX_WIDTH, CPU6_RFREG_NUM and the FSM state encodings come from the shared defines file.
REQ-033 The scoreboard is a sub-module cpu6_wb_scoreboard; output flops use the existing cpu6_dfflr-style enable flop cells.

Verification
REQ-034 ALU writes x5=0x1234 alone -> next cycle rd_wen=1, rd_idx=5, rd_data=0x1234.
REQ-035 ALU x3 and LSU x7 valid together -> lsu_wb_ready=0; ALU x3 written next cycle; LSU x7 written the cycle after ALU drops.
REQ-036 ALU valid 6 cycles with LSU x9 pending, STARVE_LIMIT=4 -> alu_hold=1 after 4 refused cycles; next cycle LSU accepted; x9 written one cycle later.
REQ-037 lsu_issue x10, then chk_rs2_idx=10 -> hazard=1 until LSU x10 handshake; hazard=0 the cycle after.
REQ-038 LSU writeback x0=0xFFFF -> lsu_wb_ready=1, rd_wen stays 0.
REQ-039 rst low during FORCE with x4 pending -> alu_hold=0, hazard=0 for chk 4, rd_wen=0 immediately.
